// File: rtl/zion_mask_rmw_pkg.sv
// -----------------------------------------------------------------------------
// zion_mask_rmw_pkg
// Shared types and helpers for the field-granular read-modify-write controller.
//   state_e     : controller FSM states (IDLE, RD, WAIT, WR)
//   MASK_MAX_W  : widest word the field_mask helper can describe
//   field_mask  : returns a mask with ones on field `idx` of a word made of
//                 width_dat/width_bit fields; all zero when idx is out of range
// -----------------------------------------------------------------------------
package zion_mask_rmw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2,
    ST_WR   = 2'd3
  } state_e;

  localparam int unsigned MASK_MAX_W = 32'd256;

  function automatic logic [MASK_MAX_W-1:0] field_mask(
    input int unsigned idx,
    input int unsigned width_dat,
    input int unsigned width_bit
  );
    logic [MASK_MAX_W-1:0] mask;
    mask = '0;
    // An index past the last field selects nothing, so the merge keeps the old word.
    if ((width_bit != 32'd0) && (idx < (width_dat / width_bit))) begin
      for (int unsigned b = 32'd0; b < MASK_MAX_W; b++) begin
        if ((b < width_dat) && ((b / width_bit) == idx)) begin
          mask[b] = 1'b1;
        end else begin
          mask[b] = 1'b0;
        end
      end
    end else begin
      mask = '0;
    end
    return mask;
  endfunction

endpackage

// File: rtl/zion_basic_circuit_lib_field_mask_dec.sv
// -----------------------------------------------------------------------------
// zion_basic_circuit_lib_field_mask_dec
// Combinational field-index to field-mask decoder.
// Ports:
//   idx_i  [WIDTH_IDX-1:0] : field index
//   mask_o [WIDTH_DAT-1:0] : ones on bits [idx*WIDTH_BIT +: WIDTH_BIT],
//                            all zero when idx >= WIDTH_DAT/WIDTH_BIT
// -----------------------------------------------------------------------------
module zion_basic_circuit_lib_field_mask_dec #(
  parameter int unsigned WIDTH_DAT = 32'd32,
  parameter int unsigned WIDTH_BIT = 32'd8,
  parameter int unsigned WIDTH_IDX = 32'd2
) (
  input  logic [WIDTH_IDX-1:0] idx_i,
  output logic [WIDTH_DAT-1:0] mask_o
);
  import zion_mask_rmw_pkg::*;

  logic [MASK_MAX_W-1:0] mask_full_s;

  // Decode the index into a maximum-width mask via the shared helper.
  always_comb begin
    mask_full_s = field_mask(32'(idx_i), WIDTH_DAT, WIDTH_BIT);
  end

  assign mask_o = mask_full_s[WIDTH_DAT-1:0];

  generate
    if (WIDTH_DAT > MASK_MAX_W) begin : g_chk_width
      $error("field_mask_dec: WIDTH_DAT exceeds MASK_MAX_W");
    end
    if (WIDTH_DAT < MASK_MAX_W) begin : g_hi_bits
      // Bits above WIDTH_DAT are zero by construction and intentionally dropped.
      logic unused_hi_s;
      assign unused_hi_s = ^mask_full_s[MASK_MAX_W-1:WIDTH_DAT];
    end
  endgenerate

endmodule

// File: rtl/zion_basic_circuit_lib_mask_rmw.sv
// -----------------------------------------------------------------------------
// zion_basic_circuit_lib_mask_rmw
// Read-modify-write controller: writes one WIDTH_BIT field into a WIDTH_DAT
// word of a single-port synchronous RAM without bit-write enables.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   iReqVld / oReqRdy    : request handshake (transfer when both high)
//   iReqAddr/Idx/Dat     : word address, field index, new field value
//   oRamEn/Wen/Addr/WDat : RAM command; oRamWDat is combinational from iRamRDat
//   iRamRDat             : RAM read data, valid RD_LAT cycles after a read
//   oDone                : one-cycle pulse on the write-back cycle
//   oBusy                : high whenever the FSM is not IDLE
// Optional feature macro ZION_MASK_RMW_FULL_WORD_EN adds iReqFull / iReqWord:
// a full-word request skips the read and writes iReqWord directly.
// -----------------------------------------------------------------------------
module zion_basic_circuit_lib_mask_rmw #(
  parameter int unsigned WIDTH_ADDR = 32'd8,
  parameter int unsigned WIDTH_DAT  = 32'd32,
  parameter int unsigned WIDTH_BIT  = 32'd8,
  parameter int unsigned WIDTH_IDX  = 32'd2,
  parameter int unsigned RD_LAT     = 32'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iReqVld,
  output logic                  oReqRdy,
  input  logic [WIDTH_ADDR-1:0] iReqAddr,
  input  logic [WIDTH_IDX-1:0]  iReqIdx,
  input  logic [WIDTH_BIT-1:0]  iReqDat,
`ifdef ZION_MASK_RMW_FULL_WORD_EN
  input  logic                  iReqFull,
  input  logic [WIDTH_DAT-1:0]  iReqWord,
`endif
  output logic                  oRamEn,
  output logic                  oRamWen,
  output logic [WIDTH_ADDR-1:0] oRamAddr,
  output logic [WIDTH_DAT-1:0]  oRamWDat,
  input  logic [WIDTH_DAT-1:0]  iRamRDat,
  output logic                  oDone,
  output logic                  oBusy
);
  import zion_mask_rmw_pkg::*;

  localparam int unsigned N_FIELD = WIDTH_DAT / WIDTH_BIT;

  generate
    if ((WIDTH_DAT % WIDTH_BIT) != 32'd0) begin : g_chk_div
      $error("mask_rmw: WIDTH_DAT must be a multiple of WIDTH_BIT");
    end
    if ((RD_LAT < 32'd1) || (RD_LAT > 32'd4)) begin : g_chk_lat
      $error("mask_rmw: RD_LAT must be within 1..4");
    end
    if (WIDTH_IDX < $clog2(N_FIELD)) begin : g_chk_idx
      $error("mask_rmw: WIDTH_IDX too narrow for the field count");
    end
  endgenerate

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [WIDTH_ADDR-1:0] addr_q, addr_d;
  logic [WIDTH_IDX-1:0]  idx_q, idx_d;
  logic [WIDTH_BIT-1:0]  dat_q, dat_d;
  logic                  rdy_q, rdy_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_wen_q, ram_wen_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  xfer_s;
  logic                  full_req_s;
  logic                  full_sel_s;
  logic [WIDTH_DAT-1:0]  mask_s;
  logic [WIDTH_DAT-1:0]  merge_s;
  logic [WIDTH_DAT-1:0]  wr_word_s;

  assign xfer_s = iReqVld && rdy_q;

`ifdef ZION_MASK_RMW_FULL_WORD_EN
  logic                  full_q, full_d;
  logic [WIDTH_DAT-1:0]  word_q, word_d;

  // Capture the full-word request fields on transfer.
  always_comb begin
    if (xfer_s) begin
      full_d = iReqFull;
      word_d = iReqWord;
    end else begin
      full_d = full_q;
      word_d = word_q;
    end
  end

  // Full-word request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      word_q <= '0;
    end else begin
      full_q <= full_d;
      word_q <= word_d;
    end
  end

  assign full_req_s = iReqFull;
  assign full_sel_s = full_q;
  assign wr_word_s  = full_q ? word_q : merge_s;
`else
  assign full_req_s = 1'b0;
  assign full_sel_s = 1'b0;
  assign wr_word_s  = merge_s;
`endif

  zion_basic_circuit_lib_field_mask_dec #(
    .WIDTH_DAT (WIDTH_DAT),
    .WIDTH_BIT (WIDTH_BIT),
    .WIDTH_IDX (WIDTH_IDX)
  ) u_mask_dec (
    .idx_i  (idx_q),
    .mask_o (mask_s)
  );

  // Keep old bits outside the field, take the replicated new value inside it.
  assign merge_s = (iRamRDat & ~mask_s) | ({N_FIELD{dat_q}} & mask_s);

  // Capture the field request on transfer.
  always_comb begin
    if (xfer_s) begin
      addr_d = iReqAddr;
      idx_d  = iReqIdx;
      dat_d  = iReqDat;
    end else begin
      addr_d = addr_q;
      idx_d  = idx_q;
      dat_d  = dat_q;
    end
  end

  // Next-state and WAIT down-counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          state_d = full_req_s ? ST_WR : ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (RD_LAT > 32'd1) begin
          state_d = ST_WAIT;
          cnt_d   = 2'(RD_LAT - 32'd2);
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_WR;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Output decode from the next state so the control outputs come straight from flops.
  always_comb begin
    rdy_d     = (state_d == ST_IDLE);
    ram_en_d  = (state_d == ST_RD) || (state_d == ST_WR);
    ram_wen_d = (state_d == ST_WR);
    done_d    = (state_d == ST_WR);
    busy_d    = (state_d != ST_IDLE);
  end

  // State, request and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      addr_q    <= '0;
      idx_q     <= '0;
      dat_q     <= '0;
      rdy_q     <= 1'b0;
      ram_en_q  <= 1'b0;
      ram_wen_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      dat_q     <= dat_d;
      rdy_q     <= rdy_d;
      ram_en_q  <= ram_en_d;
      ram_wen_q <= ram_wen_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Write data is only driven in the write-back cycle; zero otherwise (and in reset).
  always_comb begin
    if (state_q == ST_WR) begin
      oRamWDat = wr_word_s;
    end else begin
      oRamWDat = '0;
    end
  end

  assign oReqRdy  = rdy_q;
  assign oRamEn   = ram_en_q;
  assign oRamWen  = ram_wen_q;
  assign oRamAddr = addr_q;
  assign oDone    = done_q;
  assign oBusy    = busy_q;

  // Full-word select only matters in the optional build.
  logic unused_full_s;
  assign unused_full_s = full_sel_s;

endmodule

// File: tb/tb_zion_basic_circuit_lib_mask_rmw.sv
// -----------------------------------------------------------------------------
// tb_zion_basic_circuit_lib_mask_rmw
// Directed bench: DUT A (RD_LAT=1, WIDTH_IDX=3) and DUT B (RD_LAT=3,
// WIDTH_IDX=2), each attached to a behavioural RAM with matching read latency.
// -----------------------------------------------------------------------------
module tb_zion_basic_circuit_lib_mask_rmw;

  logic clk;
  logic rst_n;

  int n_chk = 0;
  int n_err = 0;

  // DUT A signals
  logic        a_vld, a_rdy, a_en, a_wen, a_done, a_busy;
  logic [7:0]  a_addr, a_ram_addr, a_dat;
  logic [2:0]  a_idx;
  logic [31:0] a_wdat, a_rdat;
`ifdef ZION_MASK_RMW_FULL_WORD_EN
  logic        a_full, b_full;
  logic [31:0] a_word, b_word;
`endif

  // DUT B signals
  logic        b_vld, b_rdy, b_en, b_wen, b_done, b_busy;
  logic [7:0]  b_addr, b_ram_addr, b_dat;
  logic [1:0]  b_idx;
  logic [31:0] b_wdat, b_rdat;

  // Bench RAM models
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] pipe_b [0:2];
  logic        pl_a, pl_b;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  int rd_cnt_a = 0, wr_cnt_a = 0, done_cnt_a = 0;
  int rd_cnt_b = 0, wr_cnt_b = 0, done_cnt_b = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  zion_basic_circuit_lib_mask_rmw #(
    .WIDTH_ADDR(8), .WIDTH_DAT(32), .WIDTH_BIT(8), .WIDTH_IDX(3), .RD_LAT(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .iReqVld(a_vld), .oReqRdy(a_rdy),
    .iReqAddr(a_addr), .iReqIdx(a_idx), .iReqDat(a_dat),
`ifdef ZION_MASK_RMW_FULL_WORD_EN
    .iReqFull(a_full), .iReqWord(a_word),
`endif
    .oRamEn(a_en), .oRamWen(a_wen), .oRamAddr(a_ram_addr), .oRamWDat(a_wdat),
    .iRamRDat(a_rdat), .oDone(a_done), .oBusy(a_busy)
  );

  zion_basic_circuit_lib_mask_rmw #(
    .WIDTH_ADDR(8), .WIDTH_DAT(32), .WIDTH_BIT(8), .WIDTH_IDX(2), .RD_LAT(3)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .iReqVld(b_vld), .oReqRdy(b_rdy),
    .iReqAddr(b_addr), .iReqIdx(b_idx), .iReqDat(b_dat),
`ifdef ZION_MASK_RMW_FULL_WORD_EN
    .iReqFull(b_full), .iReqWord(b_word),
`endif
    .oRamEn(b_en), .oRamWen(b_wen), .oRamAddr(b_ram_addr), .oRamWDat(b_wdat),
    .iRamRDat(b_rdat), .oDone(b_done), .oBusy(b_busy)
  );

  // RAM A: one-cycle read latency; non-read cycles return a poison pattern.
  always @(posedge clk) begin
    a_rdat <= (a_en && !a_wen) ? mem_a[a_ram_addr] : 32'hBAD0BAD0;
    if (a_en && !a_wen) rd_cnt_a <= rd_cnt_a + 1;
    if (a_en && a_wen) begin
      mem_a[a_ram_addr] <= a_wdat;
      wr_cnt_a <= wr_cnt_a + 1;
    end else if (pl_a) begin
      mem_a[pl_addr] <= pl_data;
    end
    if (a_done) done_cnt_a <= done_cnt_a + 1;
  end

  // RAM B: three-cycle read latency pipeline.
  always @(posedge clk) begin
    pipe_b[0] <= (b_en && !b_wen) ? mem_b[b_ram_addr] : 32'hBAD0BAD0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    if (b_en && !b_wen) rd_cnt_b <= rd_cnt_b + 1;
    if (b_en && b_wen) begin
      mem_b[b_ram_addr] <= b_wdat;
      wr_cnt_b <= wr_cnt_b + 1;
    end else if (pl_b) begin
      mem_b[pl_addr] <= pl_data;
    end
    if (b_done) done_cnt_b <= done_cnt_b + 1;
  end
  assign b_rdat = pipe_b[2];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input bit sel_b, input logic [7:0] addr, input logic [31:0] data);
    pl_a = !sel_b;
    pl_b = sel_b;
    pl_addr = addr;
    pl_data = data;
    step();
    pl_a = 1'b0;
    pl_b = 1'b0;
  endtask

  // One full RMW on DUT A (RD_LAT=1), called with DUT A idle and ready.
  task automatic op_a(input logic [7:0] addr, input logic [2:0] idx, input logic [7:0] dat,
                      input logic [31:0] exp_w, input string tag);
    int dc;
    dc = done_cnt_a;
    a_vld = 1'b1; a_addr = addr; a_idx = idx; a_dat = dat;
    step();
    a_vld = 1'b0;
    check_eq({tag, "_rd_ctl"}, {27'd0, a_busy, a_rdy, a_en, a_wen, a_done}, 32'b10100);
    check_eq({tag, "_rd_addr"}, {24'd0, a_ram_addr}, {24'd0, addr});
    step();
    check_eq({tag, "_wr_ctl"}, {27'd0, a_busy, a_rdy, a_en, a_wen, a_done}, 32'b10111);
    check_eq({tag, "_wr_dat"}, a_wdat, exp_w);
    step();
    check_eq({tag, "_idle_ctl"}, {27'd0, a_busy, a_rdy, a_en, a_wen, a_done}, 32'b01000);
    check_eq({tag, "_idle_wdat"}, a_wdat, 32'h0);
    check_eq({tag, "_mem"}, mem_a[addr], exp_w);
    check_eq({tag, "_done_n"}, 32'(done_cnt_a - dc), 32'd1);
  endtask

  initial begin
    int acc_cyc [0:1];
    int n_acc;
    int dc;
    int wc;
    int rc;
    logic acc_now;

    rst_n = 1'b0;
    a_vld = 1'b0; a_addr = 8'd0; a_idx = 3'd0; a_dat = 8'd0;
    b_vld = 1'b0; b_addr = 8'd0; b_idx = 2'd0; b_dat = 8'd0;
    pl_a = 1'b0; pl_b = 1'b0; pl_addr = 8'd0; pl_data = 32'd0;
`ifdef ZION_MASK_RMW_FULL_WORD_EN
    a_full = 1'b0; a_word = 32'd0; b_full = 1'b0; b_word = 32'd0;
`endif
    repeat (3) step();

    // Reset values
    check_eq("rst_a_ctl", {27'd0, a_busy, a_rdy, a_en, a_wen, a_done}, 32'd0);
    check_eq("rst_a_addr", {24'd0, a_ram_addr}, 32'd0);
    check_eq("rst_a_wdat", a_wdat, 32'd0);
    check_eq("rst_b_ctl", {27'd0, b_busy, b_rdy, b_en, b_wen, b_done}, 32'd0);

    preload(1'b0, 8'd5, 32'hAABBCCDD);
    preload(1'b0, 8'd2, 32'h55667788);
    preload(1'b0, 8'd7, 32'h12345678);
    preload(1'b1, 8'd0, 32'h00000000);
    preload(1'b1, 8'd4, 32'hCAFEF00D);

    // Ready rises on the first edge after release, not before
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rdy_before_edge", {31'd0, a_rdy}, 32'd0);
    step();
    check_eq("rdy_a_after_edge", {31'd0, a_rdy}, 32'd1);
    check_eq("rdy_b_after_edge", {31'd0, b_rdy}, 32'd1);

    // Basic RMW and field boundaries
    op_a(8'd5, 3'd1, 8'h11, 32'hAABB11DD, "t1_idx1");
    op_a(8'd5, 3'd3, 8'h77, 32'h77BB11DD, "t1_idx3");
    op_a(8'd5, 3'd0, 8'h00, 32'h77BB1100, "t1_idx0");

    // Out-of-range indices leave the word unchanged but still write back
    op_a(8'd7, 3'd5, 8'hEE, 32'h12345678, "oor_idx5");
    op_a(8'd7, 3'd4, 8'hEE, 32'h12345678, "oor_idx4");

    // Back-to-back requests with iReqVld held high
    dc = done_cnt_a;
    n_acc = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    a_vld = 1'b1; a_addr = 8'd2; a_idx = 3'd0; a_dat = 8'h01;
    for (int c = 0; c < 20 && n_acc < 2; c++) begin
      acc_now = a_rdy;
      step();
      if (acc_now) begin
        acc_cyc[n_acc] = c;
        n_acc++;
        if (n_acc == 1) begin
          a_idx = 3'd2; a_dat = 8'h03;
        end else begin
          a_vld = 1'b0;
        end
      end
    end
    check_eq("b2b_accepts", 32'(n_acc), 32'd2);
    check_eq("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    for (int c = 0; c < 10 && !a_rdy; c++) step();
    check_eq("b2b_idle", {31'd0, a_rdy}, 32'd1);
    check_eq("b2b_mem", mem_a[2], 32'h55037701);
    check_eq("b2b_done_n", 32'(done_cnt_a - dc), 32'd2);

`ifdef ZION_MASK_RMW_FULL_WORD_EN
    // Full-word write skips the read
    rc = rd_cnt_a;
    a_full = 1'b1; a_word = 32'hDEADBEEF;
    a_vld = 1'b1; a_addr = 8'd9; a_idx = 3'd1; a_dat = 8'h55;
    step();
    a_vld = 1'b0; a_full = 1'b0;
    check_eq("fw_wr_ctl", {27'd0, a_busy, a_rdy, a_en, a_wen, a_done}, 32'b10111);
    check_eq("fw_wr_dat", a_wdat, 32'hDEADBEEF);
    check_eq("fw_wr_addr", {24'd0, a_ram_addr}, 32'd9);
    step();
    check_eq("fw_idle_rdy", {31'd0, a_rdy}, 32'd1);
    check_eq("fw_mem", mem_a[9], 32'hDEADBEEF);
    check_eq("fw_no_read", 32'(rd_cnt_a - rc), 32'd0);
`endif

    // RD_LAT=3 timing
    dc = done_cnt_b;
    b_vld = 1'b1; b_addr = 8'd0; b_idx = 2'd3; b_dat = 8'hFF;
    step();
    b_vld = 1'b0;
    check_eq("lat3_rd", {27'd0, b_busy, b_rdy, b_en, b_wen, b_done}, 32'b10100);
    step();
    check_eq("lat3_wait1", {27'd0, b_busy, b_rdy, b_en, b_wen, b_done}, 32'b10000);
    step();
    check_eq("lat3_wait2", {27'd0, b_busy, b_rdy, b_en, b_wen, b_done}, 32'b10000);
    step();
    check_eq("lat3_wr", {27'd0, b_busy, b_rdy, b_en, b_wen, b_done}, 32'b10111);
    check_eq("lat3_wdat", b_wdat, 32'hFF000000);
    step();
    check_eq("lat3_idle", {27'd0, b_busy, b_rdy, b_en, b_wen, b_done}, 32'b01000);
    check_eq("lat3_mem", mem_b[0], 32'hFF000000);
    check_eq("lat3_done_n", 32'(done_cnt_b - dc), 32'd1);

    // Reset in WAIT discards the write
    b_vld = 1'b1; b_addr = 8'd4; b_idx = 2'd0; b_dat = 8'h99;
    step();
    b_vld = 1'b0;
    step();
    check_eq("mid_rst_in_wait", {27'd0, b_busy, b_rdy, b_en, b_wen, b_done}, 32'b10000);
    wc = wr_cnt_b;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ctl", {27'd0, b_busy, b_rdy, b_en, b_wen, b_done}, 32'd0);
    check_eq("mid_rst_addr", {24'd0, b_ram_addr}, 32'd0);
    check_eq("mid_rst_wdat", b_wdat, 32'd0);
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("mid_rst_rdy_low", {31'd0, b_rdy}, 32'd0);
    step();
    check_eq("mid_rst_rdy_high", {31'd0, b_rdy}, 32'd1);
    repeat (4) step();
    check_eq("mid_rst_no_write", 32'(wr_cnt_b - wc), 32'd0);
    check_eq("mid_rst_mem", mem_b[4], 32'hCAFEF00D);
    check_eq("mid_rst_busy", {31'd0, b_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/zion_basic_circuit_lib_mask_rmw.md
# zion_basic_circuit_lib_mask_rmw

Read-modify-write controller that writes one WIDTH_BIT-wide field into a WIDTH_DAT-wide word of a single-port synchronous RAM that has no native bit-write enable. It decodes the field index into a field mask, reads the target word, merges the new field under that mask, and writes the word back. It sits between a field-granular write requester and the RAM macro, and is the consumer stage for field-mask generation in the memory subsystem.

## Interface
Parameters:
- WIDTH_ADDR, 8, RAM word-address width
- WIDTH_DAT, 32, RAM word width
- WIDTH_BIT, 8, field width; WIDTH_DAT % WIDTH_BIT == 0 (elaboration $error otherwise)
- WIDTH_IDX, 2, field-index width; must be ≥ $clog2(WIDTH_DAT/WIDTH_BIT)
- RD_LAT, 1, RAM read latency in cycles; legal range 1..4 (elaboration $error otherwise)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- iReqVld  input  1  request valid
- oReqRdy  output  1  request ready; transfer when iReqVld && oReqRdy
- iReqAddr  input  WIDTH_ADDR  target word address
- iReqIdx  input  WIDTH_IDX  field index; field i covers bits [i*WIDTH_BIT +: WIDTH_BIT]
- iReqDat  input  WIDTH_BIT  new field value
- oRamEn  output  1  RAM access enable
- oRamWen  output  1  RAM write enable (valid only with oRamEn)
- oRamAddr  output  WIDTH_ADDR  RAM address
- oRamWDat  output  WIDTH_DAT  RAM write data
- iRamRDat  input  WIDTH_DAT  RAM read data, valid RD_LAT cycles after a read
- oDone  output  1  single-cycle pulse, coincident with the write-back cycle
- oBusy  output  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, RD, WAIT, WR.
- IDLE: oReqRdy=1. On transfer, register addr, idx, and dat, then go to RD.
- RD: one cycle, oRamEn=1, oRamWen=0, oRamAddr=registered addr. Go to WAIT if RD_LAT>1, else go to WR.
- WAIT: hold for RD_LAT-1 cycles using a down-counter, then go to WR.
- WR: one cycle, oRamEn=1, oRamWen=1, same address, oDone=1.
  - oRamWDat = (iRamRDat & ~mask) | ({N{dat}} & mask), where N = WIDTH_DAT/WIDTH_BIT.
  - oRamWDat is combinational from iRamRDat.
  - Then go to IDLE.
- mask: all ones on field idx, zeros elsewhere.
- idx ≥ N: mask is all zero. The write-back still occurs with unchanged data, and oDone still pulses.
- oReqRdy is low in RD, WAIT, and WR. No request is accepted during an operation.
- Reset values: state=IDLE, oReqRdy=0, oRamEn=0, oRamWen=0, oRamAddr=0, oRamWDat=0, oDone=0, oBusy=0.
- oReqRdy is registered and rises on the first clk edge after rst_n deasserts.
- Reset asserted mid-operation: all outputs drop asynchronously to their reset values. The in-flight write is discarded and the RAM is not written.

## Timing
- Transfer at edge T. RD cycle is T+1. WR cycle is T+1+RD_LAT. oReqRdy=1 again at T+2+RD_LAT.
- Throughput: one request per RD_LAT+2 cycles.
- Latency: request to write-back is RD_LAT+1 cycles.
- iReqVld held high continuously: the next request is accepted in the first IDLE cycle after WR. There are no bubbles beyond that.

## Configuration
- Macro ZION_MASK_RMW_FULL_WORD_EN.
- When defined:
  - Adds input iReqFull (1) and input iReqWord (WIDTH_DAT).
  - A request with iReqFull=1 skips RD and WAIT. WR occurs at T+1 with oRamWDat=iReqWord (registered), and oDone pulses at T+1.
  - iReqIdx and iReqDat are ignored for such a request.
- When undefined: these ports do not exist, and every request performs the full read-modify-write.

## Structure
- Shared package zion_mask_rmw_pkg holds:
  - the FSM state enum (IDLE, RD, WAIT, WR)
  - the helper function field_mask(idx, WIDTH_DAT, WIDTH_BIT)
- Natural sub-module: zion_basic_circuit_lib_field_mask_dec. It is combinational, takes the index and produces the WIDTH_DAT-bit field mask, and is reused by other memory-side blocks.
- The FSM, WAIT counter, and request registers live in the top module.

## Test plan
All scenarios use WIDTH_DAT=32, WIDTH_BIT=8, WIDTH_IDX=2 unless stated.
- RD_LAT=1, RAM[5]=0xAABBCCDD; request addr=5, idx=1, dat=0x11 → read at T+1, write 0xAABB11DD at T+2 with oDone=1, oReqRdy=1 at T+3.
- RD_LAT=3, RAM[0]=0x00000000; request addr=0, idx=3, dat=0xFF → write 0xFF000000 at T+4; oBusy high for T+1..T+4.
- RD_LAT=1, iReqVld held high with requests (addr=2, idx=0, dat=0x01) then (addr=2, idx=2, dat=0x03) → RAM[2]=0xXX03XX01, with accepts exactly 3 cycles apart.
- WIDTH_IDX=3, idx=5 (out of range), RAM[7]=0x12345678 → write-back of 0x12345678, oDone pulses once.
- rst_n asserted in the WAIT state (RD_LAT=3) → all outputs 0 immediately, no RAM write occurs, oReqRdy=1 one edge after release.
- ZION_MASK_RMW_FULL_WORD_EN defined, iReqFull=1, iReqWord=0xDEADBEEF, addr=9 → no read, write 0xDEADBEEF at T+1, oDone at T+1.
